// File: rtl/d3_share_pkg.sv
// d3_share_pkg: shared types and default constants for the d3_share_arb block.
//   state_t          - arbiter FSM encoding (IDLE=0, ISSUE=1, WAIT_ACK=2, RUN=3, FIN=4)
//   N_REQ_DEF        - default number of requesters
//   TIMEOUT_CYC_DEF  - default watchdog limit in cycles
package d3_share_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACK = 3'd2,
        RUN      = 3'd3,
        FIN      = 3'd4
    } state_t;
    localparam int N_REQ_DEF       = 4;
    localparam int TIMEOUT_CYC_DEF = 1023;
endpackage

// File: rtl/d3_share_arb_rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr.
//   req  in  N   request vector
//   ptr  in  PW  index searched first
//   win  out N   one-hot winner, 0 when nothing requested
//   vld  out 1   any request present
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          vld
);
    logic [PW-1:0] j;
    // Walk offsets from far to near so the nearest set bit overwrites last.
    always_comb begin
        win = '0;
        j   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = PW'((int'(ptr) + i) % N);
            if (req[j]) begin
                win    = '0;
                win[j] = 1'b1;
            end
        end
    end
    assign vld = |req;
endmodule

// File: rtl/d3_share_arb.sv
// d3_share_arb: round-robin sequencer sharing one start/ready controller among N_REQ requesters.
//   clk, rst    clock and synchronous active-high reset
//   req         level request per requester, held until its done pulse
//   ready_in    controller idle flag
//   start_out   one-cycle controller start
//   grant       one-hot owner of the current run, 0 when idle
//   done        one-cycle completion pulse to the owner
//   busy        high whenever the FSM is not in IDLE
//   timeout     watchdog abort pulse, coincident with done
// Optional watchdog: define D3_SHARE_ARB_WDOG_EN (otherwise timeout is tied 0).
module d3_share_arb
    import d3_share_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TW          = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             ready_in,
    output logic             start_out,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic             timeout
);
    localparam int PW = $clog2(N_REQ);

    state_t           state, nxt;
    logic [N_REQ-1:0] grant_q, win;
    logic             win_vld, wd_hit;
    logic [PW-1:0]    ptr, gidx;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req(req),
        .ptr(ptr),
        .win(win),
        .vld(win_vld)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant_q[i]) gidx = PW'(i);
    end

`ifdef D3_SHARE_ARB_WDOG_EN
    logic [TW-1:0] wd;
    logic          to_q;
    // Hit one cycle early so FIN lands exactly TIMEOUT_CYC cycles after WAIT_ACK entry.
    assign wd_hit = (state == WAIT_ACK || state == RUN) && wd == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            wd   <= '0;
            to_q <= 1'b0;
        end else begin
            wd   <= (state == ISSUE) ? '0 : (state == WAIT_ACK || state == RUN) ? wd + TW'(1) : wd;
            to_q <= wd_hit && !(state == RUN && ready_in);
        end
    end
    assign timeout = (state == FIN) && to_q;
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = (ready_in && win_vld) ? ISSUE : IDLE;
            ISSUE:    nxt = WAIT_ACK;
            WAIT_ACK: nxt = wd_hit ? FIN : ready_in ? WAIT_ACK : RUN;
            RUN:      nxt = (ready_in || wd_hit) ? FIN : RUN;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && nxt == ISSUE) grant_q <= win;
            if (state == FIN) begin
                grant_q <= '0;
                ptr     <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
            end
        end
    end

    assign start_out = state == ISSUE;
    assign busy      = state != IDLE;
    assign grant     = grant_q;
    assign done      = (state == FIN) ? grant_q : '0;
endmodule
